// File: rtl/main_mem_ctrl_pkg.sv
// Shared constants, FSM state type and address helpers for the main-memory
// controller and its backing array.
package mem_pkg;

   localparam int ADDR_W  = 9;
   localparam int DATA_W  = 8;
   localparam int BEATS   = 4;
   localparam int LATENCY = 4;
   localparam int BEAT_W  = $clog2(BEATS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      RBURST = 2'd2,
      WBURST = 2'd3
   } mem_state_t;

   // Line-aligned base address: the beat-offset bits are forced to zero.
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
   endfunction

   // Power-on content of a byte: low address byte, with address bit 8
   // folded onto data bit 7 so the upper half differs from the lower half.
   function automatic logic [DATA_W-1:0] init_byte(input logic [ADDR_W-1:0] addr);
      return addr[DATA_W-1:0] ^ {addr[DATA_W], {(DATA_W-1){1'b0}}};
   endfunction

endpackage

// File: rtl/main_mem_ctrl_if.sv
// Cache <-> main-memory bus. The cache side is the master, memory the slave.
//
// Handshake: ready_mem high means the controller is idle; a rd_mem/wr_mem
// level sampled on a rising edge while ready_mem is high starts exactly one
// transaction. While ready_mem is low requests are ignored (no queuing).
// rd_valid qualifies data_mem_rd beat by beat; wr_active/wr_beat say which
// write beat is being sampled from data_mem_wr on the closing edge.
interface main_mem_ctrl_if #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int BEATS  = mem_pkg::BEATS
);
   localparam int BEAT_W = $clog2(BEATS);

   logic [ADDR_W-1:0] addr_mem;
   logic              rd_mem;
   logic              wr_mem;
   logic [DATA_W-1:0] data_mem_wr;
   logic [DATA_W-1:0] data_mem_rd;
   logic              rd_valid;
   logic [BEAT_W-1:0] wr_beat;
   logic              wr_active;
   logic              ready_mem;

   modport master (
      output addr_mem, rd_mem, wr_mem, data_mem_wr,
      input  data_mem_rd, rd_valid, wr_beat, wr_active, ready_mem
   );

   modport slave (
      input  addr_mem, rd_mem, wr_mem, data_mem_wr,
      output data_mem_rd, rd_valid, wr_beat, wr_active, ready_mem
   );
endinterface

// File: rtl/main_mem_ctrl_array.sv
// Backing store: one synchronous read port, one synchronous write port.
// Each location holds the XOR difference from its power-on pattern, so a
// RAM that powers up as all zeros reads back the required initial image
// without any load step; reset leaves the contents alone.
module mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   // Read data register only moves when a read is requested.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr] ^ init_byte(rd_addr);
      end
   end

   // Output register clears on reset so the bus reads zero when idle after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   // Array write; contents are deliberately not touched by reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data ^ init_byte(wr_addr);
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller: accepts one line fill or write-back at a time,
// waits a fixed latency, then streams a wrapped burst of BEATS bytes.
module main_mem_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W  = mem_pkg::ADDR_W,
   parameter int DATA_W  = mem_pkg::DATA_W,
   parameter int BEATS   = mem_pkg::BEATS,
   parameter int LATENCY = mem_pkg::LATENCY
) (
   input  logic           clock,
   input  logic           reset,
   main_mem_ctrl_if.slave bus,
   output mem_state_t     state_dbg
);
   localparam int BCNT_W = $clog2(BEATS);
   localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   mem_state_t        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              op_wr_q, op_wr_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [BCNT_W-1:0] beat_q, beat_d;
   logic              ready_q, ready_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_active_q, wr_active_d;
   logic [BCNT_W-1:0] wr_beat_q, wr_beat_d;

   logic              lat_last;
   logic              beat_last;
   logic              rd_en;
   logic              wr_en;
   logic [BCNT_W-1:0] rd_off;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] rd_data;

   assign lat_last  = (lat_q == LAT_W'(LATENCY - 1));
   assign beat_last = (beat_q == BCNT_W'(BEATS - 1));

   // Next-state, counters and registered outputs derived from the next state.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      op_wr_d = op_wr_q;
      lat_d   = lat_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (bus.wr_mem || bus.rd_mem) begin
               base_d  = line_base(bus.addr_mem);
               op_wr_d = bus.wr_mem;   // a simultaneous read is dropped
               lat_d   = '0;
               beat_d  = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (lat_last) begin
               beat_d  = '0;
               state_d = op_wr_q ? WBURST : RBURST;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         RBURST, WBURST: begin
            beat_d = beat_q + BCNT_W'(1);
            if (beat_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d     = (state_d == IDLE);
      rd_valid_d  = (state_d == RBURST);
      wr_active_d = (state_d == WBURST);
      wr_beat_d   = wr_active_d ? beat_d : '0;
   end

   // FSM and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         base_q      <= '0;
         op_wr_q     <= 1'b0;
         lat_q       <= '0;
         beat_q      <= '0;
         ready_q     <= 1'b1;
         rd_valid_q  <= 1'b0;
         wr_active_q <= 1'b0;
         wr_beat_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         op_wr_q     <= op_wr_d;
         lat_q       <= lat_d;
         beat_q      <= beat_d;
         ready_q     <= ready_d;
         rd_valid_q  <= rd_valid_d;
         wr_active_q <= wr_active_d;
         wr_beat_q   <= wr_beat_d;
      end
   end

   // The array read is one cycle deep, so beat 0 is fetched during the last
   // WAIT cycle and each read beat prefetches the next one. Reset suppresses
   // both ports so an interrupted write commits nothing on the reset edge.
   assign rd_en   = !reset &&
                    (((state_q == WAIT) && lat_last && !op_wr_q) ||
                     ((state_q == RBURST) && !beat_last));
   assign rd_off  = (state_q == RBURST) ? (beat_q + BCNT_W'(1)) : '0;
   assign rd_addr = {base_q[ADDR_W-1:BCNT_W], rd_off};
   assign wr_en   = wr_active_q && !reset;
   assign wr_addr = {base_q[ADDR_W-1:BCNT_W], wr_beat_q};

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clock   (clock),
      .reset   (reset),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (bus.data_mem_wr)
   );

   assign bus.data_mem_rd = rd_data;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.wr_active   = wr_active_q;
   assign bus.wr_beat     = wr_beat_q;
   assign bus.ready_mem   = ready_q;
   assign state_dbg       = state_q;

endmodule

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

Main-memory model and controller that sits directly downstream of the 2-way set-associative cache (`stage1`). It answers the cache's line-fill (`rd_mem`) and write-back (`wr_mem`) requests through a `ready_mem` handshake. Each request gets a fixed access latency followed by a 4-beat byte burst. It owns the 512-byte backing store, so cache miss, eviction and fill paths can be simulated end to end without testbench-driven memory tasks.

## Interface
Parameters:
- `ADDR_W`, 9, byte address width.
- `DATA_W`, 8, data beat width.
- `BEATS`, 4, bytes per cache line (beats per burst); power of two.
- `LATENCY`, 4, wait cycles between request acceptance and first beat; ≥1.

Ports:
- `clock`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `addr_mem`  in  ADDR_W  request address; offset bits `[1:0]` ignored (line-aligned).
- `rd_mem`  in  1  line-fill request.
- `wr_mem`  in  1  write-back request.
- `data_mem_wr`  in  DATA_W  write-back beat from cache.
- `data_mem_rd`  out  DATA_W  fill beat to cache.
- `rd_valid`  out  1  `data_mem_rd` valid this cycle.
- `wr_beat`  out  2  index of the write beat sampled this cycle.
- `wr_active`  out  1  write beat sampled this cycle.
- `ready_mem`  out  1  high = idle, accepting requests.

## Operation
- States: `IDLE`, `WAIT`, `RBURST`, `WBURST`.
- Reset values: state `IDLE`, `ready_mem`=1, `rd_valid`=0, `wr_active`=0, `wr_beat`=0, `data_mem_rd`=0, counters 0.
- Reset does not clear the array. At time zero, byte[a] = a[7:0] XOR {a[8],7'b0}.
- `IDLE`:
  - `rd_mem` or `wr_mem` high on an edge → latch line base `{addr_mem[8:2],2'b00}` and the op, go `WAIT`.
  - `wr_mem` and `rd_mem` both high → write wins; the read is dropped. The cache re-issues the fill after the write-back.
- `WAIT`: count `LATENCY` cycles, then go to `RBURST` or `WBURST`.
- `RBURST`:
  - Beats 0..3 are output on consecutive cycles at base+0..base+3 with `rd_valid`=1.
  - After beat 3, go `IDLE`.
- `WBURST`:
  - `wr_beat`=0..3 on consecutive cycles with `wr_active`=1.
  - Each cycle, `data_mem_wr` is written to base+`wr_beat` at the closing edge.
  - After beat 3, go `IDLE`.
- `ready_mem`=0 in every state except `IDLE`.
- `rd_mem`/`wr_mem` are ignored while not `IDLE`; no queuing.
- The cache may hold `rd_mem`/`wr_mem` high through the transaction. A request still high on the edge entering `IDLE` is not re-accepted. A new request must be sampled while `ready_mem`=1.
- Beat address wraps within the line (`[1:0]` counter); it never crosses the line boundary.
- Reset mid-transaction → `IDLE` next edge.
  - Write beats already committed stay written.
  - No further beats are issued.

## Timing
- Let T0 be the edge that samples the request in `IDLE`.
- Cycles T0+1 .. T0+LATENCY: `WAIT`, `ready_mem`=0.
- Cycles T0+LATENCY+1 .. T0+LATENCY+4: burst beats 0..3.
- Cycle T0+LATENCY+5: `ready_mem`=1; earliest next acceptance is at its closing edge.
- Request-to-first-beat latency is `LATENCY`+1 cycles. Total occupancy is `LATENCY`+4 cycles.
- Array read is synchronous, 1 cycle. The controller presents the beat-0 read address during the last `WAIT` cycle, so read beats are gapless.
- Write-then-read of the same line returns the new data; no bypass is needed because the write completes before `IDLE`.

## Structure
- Package `mem_pkg`:
  - `ADDR_W`, `DATA_W`, `BEATS`, `LATENCY` defaults.
  - State enum `mem_state_t`.
  - Function `line_base(addr)`.
- Sub-module `mem_array`:
  - 2^ADDR_W × DATA_W.
  - 1 synchronous read port, 1 synchronous write port.
  - Time-zero init pattern.
- The controller FSM, latency counter and beat counter live in `main_mem_ctrl`.

## Test plan
- **Reset:** hold `reset`=1 for 4 cycles → `ready_mem`=1, `rd_valid`=0, `wr_active`=0, `data_mem_rd`=0.
- **Fill line 0:** `rd_mem`=1, `addr_mem`=9'h000 at T0 → `ready_mem`=0 for T0+1..T0+8; `rd_valid` at T0+5..T0+8 with data 00,01,02,03; `ready_mem`=1 at T0+9.
- **Fill upper line, offset ignored:** `addr_mem`=9'h1A7 → beats 24,25,26,27 (addresses 1A4..1A7, bit 8 flips bit 7).
- **Write-back then refill:**
  - Write at 9'h093 driving 88,99,AA,BB against `wr_beat` 0..3 at T0+5..T0+8.
  - Then read 9'h090 → beats 88,99,AA,BB.
- **Simultaneous rd and wr:** both high at 9'h010 with data 11,22,33,44 → write performed; no `rd_valid` during the transaction; a re-issued read of 9'h010 returns 11,22,33,44.
- **Reset mid-burst:**
  - `reset` during beat 1 of a read → next cycle `ready_mem`=1, `rd_valid`=0.
  - Same during beat 2 of a write of 9'h020 with C0..C3 → read returns C0,C1,22,23.
